vga_timing_gen: RTL

Parametrised VGA raster timing generator and pixel fetcher. It produces programmable H/V timing with selectable sync polarity, and issues linear frame-buffer read addresses with optional 2x pixel/line doubling. Sync and DE are delay-matched to a parametrised memory read latency, and a built-in test-pattern generator is included. It sits between the frame-buffer RAM read port and the 4-4-4 VGA pins.

---
 rtl/vga_timing_gen.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with linear frame-buffer fetch, optional 2x
// pixel/line doubling, built-in test patterns and latency-matched sync/DE.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned RD_LAT   = 1,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              scale2x,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [3:0]        red,
    output logic [3:0]        grn,
    output logic [3:0]        blu,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start,
    output logic              line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 6 bits so the checker pattern can always use bit 5.
    localparam int unsigned HW = ($clog2(H_TOTAL) > 6) ? $clog2(H_TOTAL) : 6;
    localparam int unsigned VW = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYN_S    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_E    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BAR_W      = HW'(H_ACTIVE / 8);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_S    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_E    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] HALF_LINE = ADDR_W'(H_ACTIVE / 2);

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        logic        mem;
        logic [11:0] pat;
    } stageT;

    localparam stageT IDLE_ST = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, fs: 1'b0, ls: 1'b0,
                                  mem: 1'b0, pat: 12'h000};

    logic [HW-1:0]     hCnt;
    logic [VW-1:0]     vCnt;
    logic [1:0]        modeReg;
    logic              scaleReg;
    logic [ADDR_W-1:0] addrPtr, addrNext;
    logic [ADDR_W-1:0] lineBase, lineBaseNext;
    stageT             dly [RD_LAT+1];
    stageT             st0;
    stageT             outSt;

    logic              origin, active, memRd, lineEnd, scaleCur;
    logic [1:0]        modeCur;
    logic [ADDR_W-1:0] addrCur, lineBaseCur;
    logic [2:0]        barIdx;
    logic [11:0]       pat;

    // Frame settings are taken live at the origin, otherwise from the latched copy.
    always_comb begin
        origin      = (hCnt == '0) && (vCnt == '0);
        modeCur     = origin ? mode : modeReg;
        scaleCur    = origin ? scale2x : scaleReg;
        addrCur     = origin ? base_addr : addrPtr;
        lineBaseCur = origin ? base_addr : lineBase;
        active      = en && (hCnt < H_ACT) && (vCnt < V_ACT);
        memRd       = active && (modeCur == 2'd0);
        lineEnd     = (hCnt == H_ACT_LAST);
    end

    // Raster counters; held at the origin while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (!en) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + VW'(1);
        end else begin
            hCnt <= hCnt + HW'(1);
        end
    end

    // Latch mode and scaling once per frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            modeReg  <= 2'd0;
            scaleReg <= 1'b0;
        end else if (en && origin) begin
            modeReg  <= mode;
            scaleReg <= scale2x;
        end
    end

    // Next read address; doubled mode replays each source line twice.
    always_comb begin
        addrNext     = addrPtr;
        lineBaseNext = lineBase;
        if (en && origin) lineBaseNext = base_addr;
        if (active) begin
            if (!scaleCur) begin
                addrNext = addrCur + ADDR_W'(1);
            end else begin
                addrNext = hCnt[0] ? addrCur + ADDR_W'(1) : addrCur;
                if (lineEnd) begin
                    if (!vCnt[0]) begin
                        addrNext = lineBaseCur;
                    end else begin
                        lineBaseNext = lineBaseCur + HALF_LINE;
                        addrNext     = lineBaseCur + HALF_LINE;
                    end
                end
            end
        end
    end

    // Address pointer state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addrPtr  <= '0;
            lineBase <= '0;
        end else begin
            addrPtr  <= addrNext;
            lineBase <= lineBaseNext;
        end
    end

    // Stage 1: memory read request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= memRd;
            if (memRd) rd_addr <= addrCur;
        end
    end

    // Test-pattern pixel ({B,G,R}) for the current raster position.
    always_comb begin
        pat    = 12'h000;
        barIdx = 3'(hCnt / BAR_W);
        case (modeCur)
            2'd1: begin
                case (barIdx)
                    3'd0:    pat = 12'hFFF;
                    3'd1:    pat = 12'h0FF;
                    3'd2:    pat = 12'hFF0;
                    3'd3:    pat = 12'h0F0;
                    3'd4:    pat = 12'hF0F;
                    3'd5:    pat = 12'h00F;
                    3'd6:    pat = 12'hF00;
                    default: pat = 12'h000;
                endcase
            end
            2'd2:    pat = (hCnt[5] ^ vCnt[5]) ? 12'hFFF : 12'h000;
            2'd3:    pat = 12'hF00;
            default: pat = 12'h000;
        endcase
    end

    // Raw control and pattern bundle entering the delay line.
    always_comb begin
        st0     = IDLE_ST;
        st0.hs  = (en && hCnt >= H_SYN_S && hCnt < H_SYN_E) ? HS_POL : ~HS_POL;
        st0.vs  = (en && vCnt >= V_SYN_S && vCnt < V_SYN_E) ? VS_POL : ~VS_POL;
        st0.de  = active;
        st0.fs  = active && origin;
        st0.ls  = active && (hCnt == '0);
        st0.mem = (modeCur == 2'd0);
        st0.pat = active ? pat : 12'h000;
    end

    // Delay line matching the read request plus memory latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= int'(RD_LAT); i++) dly[i] <= IDLE_ST;
        end else begin
            dly[0] <= st0;
            for (int i = 1; i <= int'(RD_LAT); i++) dly[i] <= dly[i-1];
        end
    end

    assign outSt = dly[RD_LAT];

    // Output register; colour is blanked outside the display window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            {blu, grn, red} <= 12'h000;
        end else begin
            hsync       <= outSt.hs;
            vsync       <= outSt.vs;
            de          <= outSt.de;
            frame_start <= outSt.fs;
            line_start  <= outSt.ls;
            if (!outSt.de)       {blu, grn, red} <= 12'h000;
            else if (outSt.mem)  {blu, grn, red} <= rd_data;
            else                 {blu, grn, red} <= outSt.pat;
        end
    end

endmodule
